// File: rtl/tt_um_button_count.sv
// Push-button up/down/clear/load counter tile.
// Optional macro AUTOREPEAT_EN adds hold-to-repeat on UP/DOWN.
module tt_um_button_count #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    deb;
  logic [3:0]    deb_q;
  logic [3:0]    rise;
  logic [3:0]    ev;
  logic [CW-1:0] cnt [4];
  logic [7:0]    count;
  logic          unused;

  assign unused = &{1'b0, ui_in[7:4]};

  // two-flop synchroniser per button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ui_in[3:0];
      s2 <= s1;
    end
  end

  // stability counters; level flips on the last differing cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // previous debounced level for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_q <= '0;
    else        deb_q <= deb;
  end

  assign rise = deb & ~deb_q;

`ifdef AUTOREPEAT_EN
  localparam logic [31:0] DLY = 32'(REPEAT_DELAY);
  localparam logic [31:0] PER = 32'(REPEAT_PERIOD);

  logic [31:0] tmr [2];
  logic [1:0]  act;
  logic [1:0]  first;
  logic [1:0]  rep;

  // repeat fires when the hold timer hits the current interval
  always_comb begin
    rep = '0;
    for (int i = 0; i < 2; i++) begin
      rep[i] = act[i] & deb[i] &
               (tmr[i] == (first[i] ? DLY : PER));
    end
  end

  // hold timers for UP and DOWN, armed by the press event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act   <= '0;
      first <= '0;
      for (int i = 0; i < 2; i++) tmr[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rise[i]) begin
          act[i]   <= 1'b1;
          first[i] <= 1'b1;
          tmr[i]   <= 32'd1;
        end else if (act[i] && deb[i]) begin
          if (rep[i]) begin
            first[i] <= 1'b0;
            tmr[i]   <= 32'd1;
          end else begin
            tmr[i] <= tmr[i] + 32'd1;
          end
        end else begin
          act[i] <= 1'b0;
        end
      end
    end
  end

  assign ev = (rise | {2'b00, rep}) & {4{ena}};
`else
  assign ev = rise & {4{ena}};
`endif

  // counter: CLEAR > LOAD > UP+DOWN > UP > DOWN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               count <= '0;
    else if (ev[2])           count <= '0;
    else if (ev[3])           count <= uio_in;
    else if (ev[0] && ev[1])  count <= count;
    else if (ev[0])           count <= count + 8'd1;
    else if (ev[1])           count <= count - 8'd1;
  end

  assign uo_out  = count;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_button_count.sv
// Bench for tt_um_button_count with short debounce/repeat timing.
// Reference model works from pin samples and button rules.
module tb_tt_um_button_count;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_button_count #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ui_in(ui_in),
    .uio_in(uio_in),
    .uo_out(uo_out),
    .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  logic [3:0] m_s1;
  logic [3:0] m_s2;
  logic [3:0] m_deb;
  logic [3:0] m_deb_q;
  logic [3:0] m_hist[$];
  logic [7:0] m_count;
  bit         m_hold[2];
  int         m_age[2];

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_deb = '0;
    m_deb_q = '0;
    m_count = '0;
    m_hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_hold[i] = 0;
      m_age[i] = 0;
    end
  endtask

  task automatic tick();
    logic [3:0] rise;
    logic [3:0] rep;
    logic [3:0] ev;
    bit all;
    @(posedge clk);
    rise = m_deb & ~m_deb_q;
    rep = '0;
`ifdef AUTOREPEAT_EN
    for (int i = 0; i < 2; i++) begin
      if (rise[i]) begin
        m_hold[i] = 1;
        m_age[i] = 0;
      end else if (m_hold[i] && m_deb[i]) begin
        m_age[i]++;
        if (m_age[i] == RD ||
            (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
          rep[i] = 1'b1;
      end else begin
        m_hold[i] = 0;
      end
    end
`endif
    ev = (rise | rep) & {4{ena}};
    if (ev[2]) m_count = 8'h00;
    else if (ev[3]) m_count = uio_in;
    else if (ev[0] && ev[1]) begin end
    else if (ev[0]) m_count = m_count + 8'd1;
    else if (ev[1]) m_count = m_count - 8'd1;
    m_deb_q = m_deb;
    m_hist.push_back(m_s2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    if (m_hist.size() == D) begin
      for (int b = 0; b < 4; b++) begin
        all = 1;
        for (int j = 0; j < D; j++)
          if (m_hist[j][b] == m_deb[b]) all = 0;
        if (all) m_deb[b] = ~m_deb[b];
      end
    end
    m_s2 = m_s1;
    m_s1 = ui_in[3:0];
    #1;
  endtask

  task automatic press(input logic [3:0] b, input int n);
    ui_in[3:0] = b;
    repeat (n) tick();
    ui_in[3:0] = 4'h0;
    repeat (D + 6) tick();
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL reset: out=%h/%h/%h expected 00/00/00",
               uo_out, uio_out, uio_oe);
    end
    #11 rst_n = 1'b1;
  endtask

  task automatic test_idle();
    ena = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        errors++;
        $display("FAIL idle[%0d]: out=%h/%h/%h expected 00/00/00",
                 i, uo_out, uio_out, uio_oe);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] base;
    base = uo_out;
    ui_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (uo_out !== (k < 7 ? base : base + 8'd1)) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %h expected %h",
                 k, uo_out, (k < 7 ? base : base + 8'd1));
      end
    end
    ui_in[0] = 1'b0;
    repeat (D + 6) tick();
    checks++;
    if (uo_out !== base + 8'd1 || uo_out !== m_count) begin
      errors++;
      $display("FAIL clean_release: got %h expected %h",
               uo_out, base + 8'd1);
    end
  endtask

  task automatic test_bounce_press();
    logic [7:0] base;
    base = uo_out;
    for (int i = 0; i < 4; i++) begin
      ui_in[0] = (i % 2 == 0);
      tick();
    end
    ui_in[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (uo_out !== (k < 7 ? base : base + 8'd1)) begin
        errors++;
        $display("FAIL bounce_press edge %0d: got %h expected %h",
                 k, uo_out, (k < 7 ? base : base + 8'd1));
      end
    end
    ui_in[0] = 1'b0;
    repeat (D + 6) tick();
  endtask

  task automatic test_glitch();
    logic [7:0] base;
    base = uo_out;
    ui_in[0] = 1'b1;
    repeat (3) tick();
    ui_in[0] = 1'b0;
    repeat (12) tick();
    checks++;
    if (uo_out !== base || uo_out !== m_count) begin
      errors++;
      $display("FAIL glitch: got %h expected %h", uo_out, base);
    end
  endtask

  task automatic test_wrap();
    uio_in = 8'hFF;
    press(4'b1000, 8);
    checks++;
    if (uo_out !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_load: got %h expected ff", uo_out);
    end
    press(4'b0001, 8);
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL wrap_up: got %h expected 00", uo_out);
    end
    press(4'b0010, 8);
    checks++;
    if (uo_out !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_down: got %h expected ff", uo_out);
    end
  endtask

  task automatic test_load_priority();
    uio_in = 8'hA5;
    press(4'b1000, 8);
    uio_in = 8'h3C;
    tick();
    checks++;
    if (uo_out !== 8'hA5) begin
      errors++;
      $display("FAIL load: got %h expected a5", uo_out);
    end
    press(4'b1100, 8);
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_load: got %h expected 00", uo_out);
    end
    press(4'b1000, 8);
    press(4'b0011, 8);
    checks++;
    if (uo_out !== 8'h3C) begin
      errors++;
      $display("FAIL up_down: got %h expected 3c", uo_out);
    end
  endtask

  task automatic test_ena_mask();
    logic [7:0] base;
    base = uo_out;
    ena = 1'b0;
    ui_in[0] = 1'b1;
    repeat (12) tick();
    ena = 1'b1;
    repeat (10) tick();
    ui_in[0] = 1'b0;
    repeat (D + 6) tick();
    checks++;
    if (uo_out !== base || uo_out !== m_count) begin
      errors++;
      $display("FAIL ena_mask: got %h expected %h", uo_out, base);
    end
  endtask

  task automatic test_async_reset();
    uio_in = 8'h10;
    press(4'b1000, 8);
    checks++;
    if (uo_out !== 8'h10) begin
      errors++;
      $display("FAIL areset_setup: got %h expected 10", uo_out);
    end
    ui_in[0] = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL areset_now: got %h expected 00", uo_out);
    end
    ui_in[0] = 1'b0;
    #2 rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (uo_out !== 8'h00 || uo_out !== m_count) begin
      errors++;
      $display("FAIL areset_after: got %h expected 00", uo_out);
    end
  endtask

  task automatic test_hold();
    int exp;
    uio_in = 8'h00;
    press(4'b1100, 8);
    ui_in[0] = 1'b1;
    repeat (7) tick();
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp = 1;
`ifdef AUTOREPEAT_EN
      if (k >= RD) exp = 2 + (k - RD) / RP;
`endif
      checks++;
      if (uo_out !== 8'(exp) || uo_out !== m_count) begin
        errors++;
        $display("FAIL hold_up +%0d: got %h expected %h",
                 k, uo_out, 8'(exp));
      end
    end
    ui_in[0] = 1'b0;
    repeat (D + 6) tick();
    ui_in[2] = 1'b1;
    repeat (8) tick();
    uio_in = 8'h77;
    ui_in[3] = 1'b1;
    repeat (40) tick();
    checks++;
    if (uo_out !== 8'h77 || uo_out !== m_count) begin
      errors++;
      $display("FAIL hold_clear: got %h expected 77", uo_out);
    end
    ui_in = 8'h00;
    repeat (D + 6) tick();
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 60; r++) begin
      ui_in = 8'($urandom);
      uio_in = 8'($urandom);
      ena = ($urandom_range(0, 9) != 0);
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        tick();
        checks++;
        if (uo_out !== m_count || uio_out !== 8'h00 ||
            uio_oe !== 8'h00) begin
          errors++;
          $display("FAIL random[%0d]: got %h/%h/%h expected %h/00/00",
                   r, uo_out, uio_out, uio_oe, m_count);
        end
      end
    end
    ui_in = 8'h00;
    ena = 1'b1;
    repeat (D + 6) tick();
    checks++;
    if (uo_out !== m_count) begin
      errors++;
      $display("FAIL random_end: got %h expected %h", uo_out, m_count);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clean_press();
    test_bounce_press();
    test_glitch();
    test_wrap();
    test_load_priority();
    test_ena_mask();
    test_async_reset();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
